// File: rtl/sram_ctrl_sync.sv
// Cycle-counted controller for a single-port asynchronous SRAM (CE/OE/WE, shared bus).
// All pin outputs are registered from the next-state decode; one down-counter times every phase.
module sram_ctrl_sync #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 18,
    parameter int WR_SETUP   = 2,
    parameter int WR_PULSE   = 3,
    parameter int WR_HOLD    = 1,
    parameter int RD_WAIT    = 3,
    parameter int TURNAROUND = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    localparam int MAX_A = (WR_SETUP > WR_PULSE) ? WR_SETUP : WR_PULSE;
    localparam int MAX_B = (WR_HOLD > RD_WAIT) ? WR_HOLD : RD_WAIT;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_P = (MAX_C > TURNAROUND) ? MAX_C : TURNAROUND;
    localparam int CNT_W = $clog2(MAX_P) + 1;

    typedef enum logic [2:0] {IDLE, WSETUP, WPULSE, WHOLD, RWAIT, TURN} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               last, accept, done_nxt, rd_cap;
    logic               ce_n_nxt, oe_n_nxt, we_n_nxt, drive_nxt, busy_nxt;
    logic               drive;
    logic [DATA_W-1:0]  data_out;

    function automatic logic [CNT_W-1:0] phase_len(input state_t s);
        case (s)
            WSETUP:  phase_len = CNT_W'(WR_SETUP - 1);
            WPULSE:  phase_len = CNT_W'(WR_PULSE - 1);
            WHOLD:   phase_len = CNT_W'(WR_HOLD - 1);
            RWAIT:   phase_len = CNT_W'(RD_WAIT - 1);
            TURN:    phase_len = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
            default: phase_len = '0;
        endcase
    endfunction

    assign last     = (cnt == '0);
    assign ram_data = drive ? data_out : 'z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A completing write (or read with no turnaround) may accept a held req on the same edge.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done_nxt  = 1'b0;
        rd_cap    = 1'b0;
        case (state)
            IDLE:   accept = req;
            WSETUP: if (last) state_nxt = WPULSE;
            WPULSE: if (last) state_nxt = WHOLD;
            WHOLD:  if (last) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                        accept    = req;
                    end
            RWAIT:  if (last) begin
                        done_nxt = 1'b1;
                        rd_cap   = 1'b1;
                        if (TURNAROUND > 0) begin
                            state_nxt = TURN;
                        end else begin
                            state_nxt = IDLE;
                            accept    = req;
                        end
                    end
            TURN:   if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (accept) state_nxt = wr ? WSETUP : RWAIT;

        if (state_nxt != state || accept) cnt_nxt = phase_len(state_nxt);
        else if (!last)                   cnt_nxt = cnt - CNT_W'(1);
        else                              cnt_nxt = cnt;
    end

    always_comb begin
        ce_n_nxt  = !(state_nxt inside {WSETUP, WPULSE, WHOLD, RWAIT});
        oe_n_nxt  = (state_nxt != RWAIT);
        we_n_nxt  = (state_nxt != WPULSE);
        drive_nxt = (state_nxt inside {WSETUP, WPULSE, WHOLD});
        busy_nxt  = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_we_n <= 1'b1;
            drive    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
            ram_addr <= '0;
            data_out <= '0;
        end else begin
            ram_ce_n <= ce_n_nxt;
            ram_oe_n <= oe_n_nxt;
            ram_we_n <= we_n_nxt;
            drive    <= drive_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            if (rd_cap) rdata <= ram_data;
            if (accept) begin
                ram_addr <= addr;
                data_out <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl_sync.sv
// Directed bench for sram_ctrl_sync: default instance plus a TURNAROUND=2 instance,
// each with a small behavioural SRAM on its bus.
module tb_sram_ctrl_sync;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req = 1'b0, wr = 1'b0;
    logic [17:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        busy, done, ram_ce_n, ram_oe_n, ram_we_n;
    logic [17:0] ram_addr;
    wire  [15:0] ram_data;

    logic        req2 = 1'b0, wr2 = 1'b0;
    logic [17:0] addr2 = '0;
    logic [15:0] wdata2 = '0;
    logic [15:0] rdata2;
    logic        busy2, done2, ram_ce_n2, ram_oe_n2, ram_we_n2;
    logic [17:0] ram_addr2;
    wire  [15:0] ram_data2;

    int checks = 0, errors = 0;
    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    sram_ctrl_sync dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
        .ram_we_n(ram_we_n), .ram_addr(ram_addr), .ram_data(ram_data)
    );

    sram_ctrl_sync #(.TURNAROUND(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .wr(wr2), .addr(addr2), .wdata(wdata2),
        .rdata(rdata2), .busy(busy2), .done(done2), .ram_ce_n(ram_ce_n2), .ram_oe_n(ram_oe_n2),
        .ram_we_n(ram_we_n2), .ram_addr(ram_addr2), .ram_data(ram_data2)
    );

    // SRAM models: drive on CE&OE, store while CE&WE are low.
    assign ram_data  = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[7:0]] : 'z;
    assign ram_data2 = (!ram_ce_n2 && !ram_oe_n2) ? 16'h5A5A : 'z;
    always @(posedge clk) if (!ram_ce_n && !ram_we_n) mem[ram_addr[7:0]] <= ram_data;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks += 6;
        if (ram_ce_n !== 1'b1) begin errors++; $display("FAIL rst_ce_n got %b exp 1", ram_ce_n); end
        if (ram_oe_n !== 1'b1) begin errors++; $display("FAIL rst_oe_n got %b exp 1", ram_oe_n); end
        if (ram_we_n !== 1'b1) begin errors++; $display("FAIL rst_we_n got %b exp 1", ram_we_n); end
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %b%b exp 00", busy, done); end
        if (rdata !== 16'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0000", rdata); end
        if (ram_addr !== 18'h0) begin errors++; $display("FAIL rst_addr got %h exp 00000", ram_addr); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write();
        req = 1'b1; wr = 1'b1; addr = 18'h00012; wdata = 16'hA5C3;
        step();
        req = 1'b0;
        checks++;
        if (ram_addr !== 18'h00012) begin errors++; $display("FAIL wr_addr got %h exp 00012", ram_addr); end
        for (int c = 1; c <= 8; c++) begin
            checks += 6;
            if (ram_we_n !== ((c >= 3 && c <= 5) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL wr_we_n c=%0d got %b", c, ram_we_n); end
            if (done !== (c == 7)) begin errors++; $display("FAIL wr_done c=%0d got %b exp %b", c, done, c == 7); end
            if (busy !== (c <= 6)) begin errors++; $display("FAIL wr_busy c=%0d got %b exp %b", c, busy, c <= 6); end
            if (ram_ce_n !== (c > 6)) begin errors++; $display("FAIL wr_ce_n c=%0d got %b exp %b", c, ram_ce_n, c > 6); end
            if (ram_oe_n !== 1'b1) begin errors++; $display("FAIL wr_oe_n c=%0d got %b exp 1", c, ram_oe_n); end
            if ((c <= 6) ? (ram_data !== 16'hA5C3) : (ram_data === 16'hA5C3)) begin
                errors++; $display("FAIL wr_drive c=%0d got %h driven-expected %b", c, ram_data, c <= 6);
            end
            step();
        end
    endtask

    task automatic test_read();
        req = 1'b1; wr = 1'b0; addr = 18'h00012;
        step();
        req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks += 5;
            if (ram_oe_n !== (c > 3)) begin errors++; $display("FAIL rd_oe_n c=%0d got %b exp %b", c, ram_oe_n, c > 3); end
            if (done !== (c == 4)) begin errors++; $display("FAIL rd_done c=%0d got %b exp %b", c, done, c == 4); end
            if (busy !== (c <= 4)) begin errors++; $display("FAIL rd_busy c=%0d got %b exp %b", c, busy, c <= 4); end
            if (ram_we_n !== 1'b1) begin errors++; $display("FAIL rd_we_n c=%0d got %b exp 1", c, ram_we_n); end
            if (rdata !== ((c >= 4) ? 16'hA5C3 : 16'h0000)) begin errors++; $display("FAIL rd_rdata c=%0d got %h", c, rdata); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        req = 1'b1; wr = 1'b1; addr = 18'h00100; wdata = 16'h1111;
        step();
        addr = 18'h00101; wdata = 16'h2222;
        for (int c = 1; c <= 14; c++) begin
            checks += 4;
            if (ram_we_n !== (((c >= 3 && c <= 5) || (c >= 9 && c <= 11)) ? 1'b0 : 1'b1)) begin
                errors++; $display("FAIL b2b_we_n c=%0d got %b", c, ram_we_n);
            end
            if (done !== (c == 7 || c == 13)) begin errors++; $display("FAIL b2b_done c=%0d got %b", c, done); end
            if (c <= 12 && ram_addr !== ((c <= 6) ? 18'h00100 : 18'h00101)) begin
                errors++; $display("FAIL b2b_addr c=%0d got %h", c, ram_addr);
            end
            if (c <= 12 && ram_data !== ((c <= 6) ? 16'h1111 : 16'h2222)) begin
                errors++; $display("FAIL b2b_data c=%0d got %h", c, ram_data);
            end
            if (c == 7) req = 1'b0;
            step();
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_turnaround();
        int first_wr = 0;
        req2 = 1'b1; wr2 = 1'b0; addr2 = 18'h00033;
        step();
        wr2 = 1'b1; wdata2 = 16'h3C3C;
        for (int c = 1; c <= 13; c++) begin
            checks += 4;
            if (ram_oe_n2 !== (c > 3)) begin errors++; $display("FAIL ta_oe_n c=%0d got %b exp %b", c, ram_oe_n2, c > 3); end
            if (done2 !== (c == 4 || c == 13)) begin errors++; $display("FAIL ta_done c=%0d got %b", c, done2); end
            if (busy2 !== !(c == 6 || c == 13)) begin errors++; $display("FAIL ta_busy c=%0d got %b", c, busy2); end
            if (c >= 4 && rdata2 !== 16'h5A5A) begin errors++; $display("FAIL ta_rdata c=%0d got %h exp 5a5a", c, rdata2); end
            if (c >= 7 && c <= 12) begin
                checks++;
                if (ram_data2 !== 16'h3C3C) begin errors++; $display("FAIL ta_drive c=%0d got %h exp 3c3c", c, ram_data2); end
            end
            if (first_wr == 0 && !ram_ce_n2 && ram_oe_n2) first_wr = c;
            if (c == 7) req2 = 1'b0;
            step();
        end
        checks++;
        if (first_wr != 7) begin errors++; $display("FAIL ta_first_write got %0d exp 7", first_wr); end
    endtask

    task automatic test_reset_mid();
        req = 1'b1; wr = 1'b1; addr = 18'h00055; wdata = 16'h0F0F;
        step();
        req = 1'b0;
        step(); step(); step();
        checks++;
        if (ram_we_n !== 1'b0) begin errors++; $display("FAIL rm_pre_we_n got %b exp 0", ram_we_n); end
        rst = 1'b1;
        #1;
        checks += 4;
        if (ram_we_n !== 1'b1 || ram_ce_n !== 1'b1) begin errors++; $display("FAIL rm_strobes got we%b ce%b exp 11", ram_we_n, ram_ce_n); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rm_done got %b exp 0", done); end
        if (ram_data === 16'h0F0F) begin errors++; $display("FAIL rm_bus got %h exp released", ram_data); end
        step();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || ram_we_n !== 1'b1) begin
                errors++; $display("FAIL rm_after c=%0d got done%b busy%b we%b", c, done, busy, ram_we_n);
            end
            step();
        end
    endtask

    task automatic test_ignore();
        req = 1'b1; wr = 1'b0; addr = 18'h00012;
        step();
        req = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            checks += 4;
            if (ram_we_n !== 1'b1) begin errors++; $display("FAIL ig_we_n c=%0d got %b exp 1", c, ram_we_n); end
            if (done !== (c == 4)) begin errors++; $display("FAIL ig_done c=%0d got %b exp %b", c, done, c == 4); end
            if (busy !== (c <= 4)) begin errors++; $display("FAIL ig_busy c=%0d got %b exp %b", c, busy, c <= 4); end
            if (ram_addr !== 18'h00012) begin errors++; $display("FAIL ig_addr c=%0d got %h exp 00012", c, ram_addr); end
            if (c >= 4) begin
                checks++;
                if (rdata !== 16'hA5C3) begin errors++; $display("FAIL ig_rdata c=%0d got %h exp a5c3", c, rdata); end
            end
            if (c == 2) begin req = 1'b1; wr = 1'b1; addr = 18'h00040; wdata = 16'hDEAD; end
            if (c == 3) req = 1'b0;
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_turnaround();
        test_reset_mid();
        test_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
